// File: rtl/ln_sum_exp_arbiter_if.sv
// Requester-side bundle for ln_sum_exp_arbiter: operand handshake plus routed results.
interface ln_sum_exp_arbiter_if #(
  parameter int BITS    = 16,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*BITS-1:0] req_a;
  logic [NUM_REQ*BITS-1:0] req_b;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [BITS-1:0]         resp_c;

  modport master (output req_valid, req_a, req_b, input req_ready, resp_valid, resp_c);
  modport slave  (input req_valid, req_a, req_b, output req_ready, resp_valid, resp_c);
endinterface

// File: rtl/ln_sum_exp_arbiter.sv
// Round-robin sharing of one pipelined ln_sum_exp datapath with tagged result routing.
// Optional latency checker (lat_err output) enabled by defining LSE_ARB_LAT_CHECK_EN.
module ln_sum_exp_arbiter #(
  parameter int BITS    = 16,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ln_sum_exp_arbiter_if.slave req_if,
  output logic            dp_in_valid,
  output logic [BITS-1:0] dp_a,
  output logic [BITS-1:0] dp_b,
  input  logic            dp_out_valid,
  input  logic [BITS-1:0] dp_c,
  output logic            busy
`ifdef LSE_ARB_LAT_CHECK_EN
  ,
  output logic            lat_err
`endif
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [CNT_W-1:0]   cnt [NUM_REQ];
  logic [ID_W-1:0]    dp_id;
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [LATENCY];
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [BITS-1:0]    resp_c_q;
  logic               resp_fire;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_if.req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
  end

  // Scan from the pointer with wrap-around; first eligible requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    grant = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  end

  assign req_if.req_ready  = grant;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_c     = resp_c_q;
  assign resp_fire         = dp_out_valid && tag_v[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      dp_in_valid <= 1'b0;
      dp_a        <= '0;
      dp_b        <= '0;
      dp_id       <= '0;
    end else begin
      dp_in_valid <= grant_any;
      if (grant_any) begin
        ptr   <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        dp_a  <= req_if.req_a[int'(grant_id)*BITS +: BITS];
        dp_b  <= req_if.req_b[int'(grant_id)*BITS +: BITS];
        dp_id <= grant_id;
      end
    end
  end

  // Tag enters alongside dp_in_valid so the tail lines up with dp_out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= dp_in_valid;
      tag_id[0] <= dp_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_c_q     <= '0;
      busy         <= 1'b0;
    end else begin
      resp_valid_q <= resp_fire ? (NUM_REQ'(1) << tag_id[LATENCY-1]) : '0;
      if (resp_fire) resp_c_q <= dp_c;
      busy <= (|tag_v) | dp_in_valid | (|resp_valid_q);
    end
  end

  // A same-cycle grant and response for one requester cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && !resp_valid_q[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (!grant[i] && resp_valid_q[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

`ifdef LSE_ARB_LAT_CHECK_EN
  localparam int ARM_W = $clog2(LATENCY + 2);
  logic [ARM_W-1:0] arm_cnt;

  // Hold off until stale datapath pulses from before reset have drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt <= ARM_W'(LATENCY + 1);
      lat_err <= 1'b0;
    end else begin
      if (arm_cnt != '0)                           arm_cnt <= arm_cnt - 1'b1;
      else if (dp_out_valid != tag_v[LATENCY-1])   lat_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ln_sum_exp_arbiter.sv
// Randomized bench for ln_sum_exp_arbiter with an in-bench reference model and stand-in datapath.
module tb_ln_sum_exp_arbiter;
  localparam int BITS = 16;
  localparam int N    = 4;
  localparam int LAT  = 4;
  localparam int MOUT = 2;
  localparam int RDLY = LAT + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic dp_in_valid, dp_out_valid, busy;
  logic [BITS-1:0] dp_a, dp_b, dp_c;
`ifdef LSE_ARB_LAT_CHECK_EN
  logic lat_err;
`endif

  ln_sum_exp_arbiter_if #(.BITS(BITS), .NUM_REQ(N)) rif ();

  ln_sum_exp_arbiter #(.BITS(BITS), .NUM_REQ(N), .LATENCY(LAT), .MAX_OUT(MOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_if(rif),
    .dp_in_valid(dp_in_valid), .dp_a(dp_a), .dp_b(dp_b),
    .dp_out_valid(dp_out_valid), .dp_c(dp_c), .busy(busy)
`ifdef LSE_ARB_LAT_CHECK_EN
    , .lat_err(lat_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in datapath: only routing is under test; (0,0) gives fp16 ln2.
  function automatic logic [BITS-1:0] dp_fn(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    return a + b + 16'h398C;
  endfunction

  int dp_lat = LAT;
  logic [7:0] pv = '0;
  logic [BITS-1:0] pc [8];
  always @(posedge clk) begin
    pv    <= {pv[6:0], dp_in_valid};
    pc[0] <= dp_fn(dp_a, dp_b);
    for (int k = 1; k < 8; k++) pc[k] <= pc[k-1];
  end
  assign dp_out_valid = pv[dp_lat-1];
  assign dp_c         = pc[dp_lat-1];

  // Model: history ring of grants per cycle; everything derives from grant times.
  bit chk_en = 1'b1;
  int ncyc = 16;
  bit hv [16];
  int hid [16];
  logic [BITS-1:0] ha [16], hb [16];
  int m_ptr = 0;
  logic [BITS-1:0] m_la = '0, m_lb = '0, m_lc = '0;

  always @(negedge clk) begin : compare
    int cur, gid, idx, outst, p;
    logic [N-1:0] exp_rdy;
    bit exp_busy;
    cur = ncyc % 16;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) hv[k] = 1'b0;
      m_ptr = 0; m_la = '0; m_lb = '0; m_lc = '0;
      chk("rst_ready", 32'(rif.req_ready), 32'(0));
      chk("rst_dp_in_valid", 32'(dp_in_valid), 32'(0));
      chk("rst_resp_valid", 32'(rif.resp_valid), 32'(0));
      chk("rst_resp_c", 32'(rif.resp_c), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
`ifdef LSE_ARB_LAT_CHECK_EN
      chk("rst_lat_err", 32'(lat_err), 32'(0));
`endif
    end else if (chk_en) begin
      gid = -1;
      for (int j = 0; j < N; j++) begin
        idx = (m_ptr + j) % N;
        outst = 0;
        for (int k = 1; k <= RDLY; k++) begin
          p = (ncyc - k) % 16;
          if (hv[p] && hid[p] == idx) outst++;
        end
        if (gid < 0 && rif.req_valid[idx] && outst < MOUT) gid = idx;
      end
      exp_rdy = (gid >= 0) ? N'(1) << gid : '0;
      chk("req_ready", 32'(rif.req_ready), 32'(exp_rdy));
      hv[cur] = (gid >= 0);
      hid[cur] = gid;
      if (gid >= 0) begin
        ha[cur] = rif.req_a[gid*BITS +: BITS];
        hb[cur] = rif.req_b[gid*BITS +: BITS];
        m_ptr = (gid + 1) % N;
      end
      p = (ncyc - 1) % 16;
      chk("dp_in_valid", 32'(dp_in_valid), 32'(hv[p]));
      if (hv[p]) begin m_la = ha[p]; m_lb = hb[p]; end
      chk("dp_a", 32'(dp_a), 32'(m_la));
      chk("dp_b", 32'(dp_b), 32'(m_lb));
      p = (ncyc - RDLY) % 16;
      chk("resp_valid", 32'(rif.resp_valid), hv[p] ? 32'(N'(1) << hid[p]) : 32'(0));
      if (hv[p]) m_lc = dp_fn(ha[p], hb[p]);
      chk("resp_c", 32'(rif.resp_c), 32'(m_lc));
      exp_busy = 1'b0;
      for (int k = 2; k <= RDLY + 1; k++) if (hv[(ncyc - k) % 16]) exp_busy = 1'b1;
      chk("busy", 32'(busy), 32'(exp_busy));
`ifdef LSE_ARB_LAT_CHECK_EN
      chk("lat_err_quiet", 32'(lat_err), 32'(0));
`endif
    end else begin
      hv[cur] = 1'b0;
    end
    ncyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_ops();
    rif.req_a = {$urandom(), $urandom()};
    rif.req_b = {$urandom(), $urandom()};
  endtask

  initial begin
    rst_n = 1'b0;
    rif.req_valid = '0;
    rif.req_a = '0;
    rif.req_b = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Single op from requester 2 with zero operands.
    step();
    rif.req_valid = 4'b0100;
    at_neg(); chk("single_ready", 32'(rif.req_ready), 32'h4);
    step();
    rif.req_valid = '0;
    at_neg(); chk("single_dp_in", 32'(dp_in_valid), 32'h1);
    repeat (4) step();
    step();
    at_neg();
    chk("single_resp_valid", 32'(rif.resp_valid), 32'h4);
    chk("single_resp_c", 32'(rif.resp_c), 32'h398C);
    step(); at_neg(); chk("single_busy_tail", 32'(busy), 32'h1);
    step(); at_neg(); chk("single_busy_low", 32'(busy), 32'h0);

    // Outstanding limit on requester 0 alone.
    repeat (10) step();
    rif.req_valid = 4'b0001;
    rand_ops();
    for (int t = 0; t < 9; t++) begin
      at_neg();
      chk("limit_ready0", 32'(rif.req_ready[0]), (t < 2 || t >= 7) ? 32'h1 : 32'h0);
      step();
      rand_ops();
    end
    rif.req_valid = '0;

    // Requester 1 grant coinciding with its own response.
    repeat (12) step();
    rif.req_valid = 4'b0010;
    step();
    rif.req_valid = '0;
    repeat (5) step();
    rif.req_valid = 4'b0010;
    at_neg(); chk("simul_ready_h6", 32'(rif.req_ready), 32'h2);
    step(); at_neg(); chk("simul_ready_h7", 32'(rif.req_ready), 32'h2);
    step(); at_neg(); chk("simul_ready_h8", 32'(rif.req_ready), 32'h0);
    step();
    rif.req_valid = '0;

    // Random traffic.
    for (int t = 0; t < 1500; t++) begin
      step();
      rif.req_valid = N'($urandom_range(0, 15));
      rand_ops();
    end
    rif.req_valid = '0;

    // Reset with three ops in flight.
    repeat (12) step();
    rif.req_valid = 4'b1111;
    repeat (3) step();
    rif.req_valid = '0;
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      at_neg(); chk("post_rst_no_resp", 32'(rif.resp_valid), 32'h0);
      step();
    end

    // Round-robin from pointer 0 with everyone requesting.
    rif.req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      at_neg(); chk("rr_order", 32'(rif.req_ready), 32'(N'(1) << (t % N)));
      step();
      rand_ops();
    end
    repeat (20) begin step(); rand_ops(); end
    rif.req_valid = '0;
    repeat (12) step();

`ifdef LSE_ARB_LAT_CHECK_EN
    // Datapath one cycle slower than the arbiter expects.
    chk_en = 1'b0;
    rst_n = 1'b0;
    dp_lat = LAT + 1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    rif.req_valid = 4'b0001;
    at_neg(); chk("lat_err_before", 32'(lat_err), 32'h0);
    step();
    rif.req_valid = '0;
    repeat (8) step();
    at_neg(); chk("lat_err_set", 32'(lat_err), 32'h1);
    repeat (10) step();
    at_neg(); chk("lat_err_sticky", 32'(lat_err), 32'h1);
    rst_n = 1'b0;
    at_neg(); chk("lat_err_cleared", 32'(lat_err), 32'h0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ln_sum_exp_arbiter.md
Name: ln_sum_exp_arbiter

Overview:
- Shares one pipelined ln_sum_exp datapath between NUM_REQ requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- Arbitration is round-robin. Each accepted operation carries a requester tag through a delay line matched to the datapath latency, and each result is routed back to its owner.
- A per-requester outstanding-operation limit throttles any one requester from flooding the datapath.

Parameters:
- BITS, 16, operand/result width.
- NUM_REQ, 4, number of requesters (2..16).
- LATENCY, 4, cycles from dp_in_valid high to the matching dp_out_valid high; fixed property of the attached datapath.
- MAX_OUT, 4, maximum in-flight operations per requester (1..2*LATENCY).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  operand pair valid, one bit per requester.
- req_ready  output  NUM_REQ  grant/accept, one-hot or zero.
- req_a  input  NUM_REQ*BITS  operand a; requester i occupies bits [i*BITS +: BITS].
- req_b  input  NUM_REQ*BITS  operand b, same packing.
- resp_valid  output  NUM_REQ  result valid, one-hot or zero.
- resp_c  output  BITS  result, shared by all requesters.
- dp_in_valid  output  1  to datapath in_valid.
- dp_a  output  BITS  to datapath a.
- dp_b  output  BITS  to datapath b.
- dp_out_valid  input  1  from datapath out_valid.
- dp_c  input  BITS  from datapath c.
- busy  output  1  high while any operation is in flight.

Behaviour:
- **Reset.** All outputs reset to 0. The round-robin pointer resets to 0. Tag pipe and outstanding counters are cleared.
- **Eligibility.** Requester i is eligible when req_valid[i] is high and its outstanding count is below MAX_OUT.
- **Grant.**
  - req_ready is combinational from eligibility and the pointer.
  - The first eligible requester at or after the pointer, with wrap-around, gets req_ready high.
  - At most one grant per cycle.
  - No eligible requester means req_ready is all zero.
- **Handshake.** Occurs when req_valid[i] and req_ready[i] are both high.
  - Next cycle: dp_in_valid=1, and dp_a/dp_b hold the registered operands of requester i.
  - Otherwise dp_in_valid=0 and dp_a/dp_b hold their previous values.
  - The pointer moves to (i+1) mod NUM_REQ on a handshake only; with no grant it stays unchanged.
- **Tag pipe.**
  - LATENCY-deep shift register of {valid, id}, entered in the same cycle dp_in_valid is driven high.
  - The tail entry aligns with dp_out_valid.
- **Response.**
  - When dp_out_valid and the tail tag are both valid: next cycle resp_valid[id]=1 and resp_c=dp_c.
  - Otherwise resp_valid is 0 and resp_c holds its previous value.
  - dp_out_valid with an invalid tail tag is dropped.
  - End-to-end latency from handshake to resp_valid is LATENCY+2 cycles.
  - Requesters must accept results; there is no response backpressure.
- **Outstanding counters.**
  - Per requester, width $clog2(MAX_OUT+1).
  - +1 on that requester's handshake; -1 on its resp_valid.
  - Both in the same cycle: unchanged.
  - A counter never exceeds MAX_OUT; it saturates because eligibility gating blocks further grants.
- **Throughput.** Full throughput is one operation per cycle, sustained across requesters.
- **busy.** Registered OR of all tag valids, dp_in_valid and resp_valid.
- **Reset mid-operation.** In-flight work is abandoned. The datapath has no reset, so its stale dp_out_valid pulses meet invalid tags and are dropped. No resp_valid is generated for work accepted before reset.

Optional Feature:
- Macro: LSE_ARB_LAT_CHECK_EN.
- **When defined:**
  - Adds output lat_err (1 bit, resets 0, sticky until reset).
  - lat_err sets when dp_out_valid differs from the tail tag valid.
  - The checker arms LATENCY+1 cycles after reset release, so stale post-reset pulses do not flag.
- **When undefined:** no port and no logic. Mismatches are silently handled per the Response rule.

Test Plan:
- **Single op.** NUM_REQ=4, LATENCY=4, model datapath. Requester 2 presents a=0x0000, b=0x0000 for one handshake → dp_in_valid 1 cycle later; resp_valid=4'b0100 with resp_c=0x398C (ln 2) exactly 6 cycles after handshake; busy falls after.
- **Round-robin.** All four requesters hold req_valid=1 continuously → grant order 0,1,2,3,0,… one per cycle; each resp_valid returns to the matching requester in issue order.
- **Outstanding limit.** MAX_OUT=2; requester 0 is the only one valid, continuously → two grants, then req_ready[0]=0 until its first resp_valid; a third grant occurs the cycle after resp, and the count never exceeds 2.
- **Simultaneous inc/dec.** Requester 1 handshake coincides with its own resp_valid → counter unchanged, eligibility held.
- **Reset mid-flight.** Assert rst_n=0 with 3 ops in flight, release → no resp_valid for those ops despite datapath pulses; pointer=0, grants resume from requester 0.
- **Latency check (macro defined).** Model datapath configured with latency 5 against LATENCY=4 → lat_err=1 on the first mismatch and stays 1 until reset.
